// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier; flags are registered alongside the result.
module alu_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             SC_in,
    input  logic [3:0]       OP,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             SC_out,
    output logic             Zero,
    output logic             Parity,
    output logic             Odd,
    output logic             Illegal,
    output logic             Busy
);

    localparam int unsigned W2     = 2 * WIDTH;
    localparam logic [3:0]  OP_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [W2-1:0]      acc, acc_nxt, mcand, mcand_nxt, mul_sum;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt, sh_amt;
    logic [WIDTH-1:0]   out_nxt, alu_res;
    logic               sc_nxt, ill_nxt, alu_sc, alu_ill, accept, over;
    logic [WIDTH:0]     sum;
    logic [W2:0]        shl_t, shr_t;

    assign In_ready = Reset_n && ((state == IDLE) || ((state == DONE) && Out_ready));
    assign accept   = In_valid && In_ready;
    assign mul_sum  = acc + (mplier[0] ? mcand : '0);

    // Single-cycle operations; shift amount clamped to WIDTH so the fill saturates
    always_comb begin : alu
        alu_res = '0;
        alu_sc  = 1'b0;
        alu_ill = 1'b0;
        sum     = '0;
        over    = InputB > WIDTH'(WIDTH);
        sh_amt  = (InputB >= WIDTH'(WIDTH)) ? SHAMT_W'(WIDTH) : SHAMT_W'(InputB);
        shl_t   = {1'b0, InputA, {WIDTH{SC_in}}} << sh_amt;
        shr_t   = {{WIDTH{SC_in}}, InputA, 1'b0} >> sh_amt;
        case (OP)
            4'd0: begin
                sum     = {1'b0, InputA} + {1'b0, InputB} + (WIDTH+1)'(SC_in);
                alu_res = sum[WIDTH-1:0];
                alu_sc  = sum[WIDTH];
            end
            4'd1: begin
                sum     = {1'b0, InputA} - {1'b0, InputB} - (WIDTH+1)'(SC_in);
                alu_res = sum[WIDTH-1:0];
                alu_sc  = sum[WIDTH];
            end
            4'd2: alu_res = InputA & InputB;
            4'd3: alu_res = InputA | InputB;
            4'd4: alu_res = WIDTH'(^InputB);
            4'd5: begin
                alu_res = shl_t[W2-1:WIDTH];
                alu_sc  = over ? 1'b0 : shl_t[W2];
            end
            4'd6: begin
                alu_res = shr_t[WIDTH:1];
                alu_sc  = over ? 1'b0 : shr_t[0];
            end
            4'd7:  alu_res = WIDTH'(InputA == InputB);
            4'd8:  alu_res = WIDTH'(InputA != InputB);
            4'd9:  alu_res = WIDTH'(InputA < InputB);
            4'd10: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state and next-register values
    always_comb begin : fsm
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        out_nxt    = Out;
        sc_nxt     = SC_out;
        ill_nxt    = Illegal;
        case (state)
            BUSY: begin
                acc_nxt    = mul_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + SHAMT_W'(1);
                if (cnt == SHAMT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    out_nxt   = mul_sum[WIDTH-1:0];
                    sc_nxt    = |mul_sum[W2-1:WIDTH];
                    ill_nxt   = 1'b0;
                end
            end
            DONE: if (Out_ready) state_nxt = IDLE;
            default: state_nxt = state;
        endcase
        if (accept) begin
            if (OP == OP_MUL) begin
                state_nxt  = BUSY;
                acc_nxt    = '0;
                mcand_nxt  = {{WIDTH{1'b0}}, InputA};
                mplier_nxt = InputB;
                cnt_nxt    = '0;
            end else begin
                state_nxt = DONE;
                out_nxt   = alu_res;
                sc_nxt    = alu_sc;
                ill_nxt   = alu_ill;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            Out       <= '0;
            SC_out    <= 1'b0;
            Zero      <= 1'b0;
            Parity    <= 1'b0;
            Odd       <= 1'b0;
            Illegal   <= 1'b0;
            Busy      <= 1'b0;
            Out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
            Out       <= out_nxt;
            SC_out    <= sc_nxt;
            Zero      <= ~|out_nxt;
            Parity    <= ^out_nxt;
            Odd       <= out_nxt[0];
            Illegal   <= ill_nxt;
            Busy      <= (state_nxt == BUSY);
            Out_valid <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe (WIDTH=8) against a
// transaction-level reference model of results and handshake timing.
module tb_alu_pipe;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         Clk = 1'b0;
    logic         Reset_n, In_valid, In_ready, SC_in, Out_valid, Out_ready;
    logic [W-1:0] InputA, InputB, Out;
    logic [3:0]   OP;
    logic         SC_out, Zero, Parity, Odd, Illegal, Busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model: result register contents, visible-valid, MUL cycles remaining
    logic [9:0] m_res, p_res;
    int         m_valid, m_left, m_just_reset;

    alu_pipe #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
        .InputA(InputA), .InputB(InputB), .SC_in(SC_in), .OP(OP),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out(Out), .SC_out(SC_out),
        .Zero(Zero), .Parity(Parity), .Odd(Odd), .Illegal(Illegal), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference result as {illegal, sc, out}, from plain integer arithmetic
    function automatic logic [9:0] ref_op(input int a, input int b, input int c, input int op);
        int r, sc, ill, s;
        r = 0; sc = 0; ill = 0; s = 0;
        case (op)
            0: begin s = a + b + c; r = s & MASK; sc = (s > MASK) ? 1 : 0; end
            1: begin s = a - b - c; r = s & MASK; sc = (s < 0) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = $countones(b) % 2;
            5: if (b == 0) r = a;
               else if (b >= W) begin r = c ? MASK : 0; sc = (b == W) ? (a & 1) : 0; end
               else begin r = ((a << b) | (c ? ((1 << b) - 1) : 0)) & MASK; sc = (a >> (W - b)) & 1; end
            6: if (b == 0) r = a;
               else if (b >= W) begin r = c ? MASK : 0; sc = (b == W) ? ((a >> (W - 1)) & 1) : 0; end
               else begin r = (a >> b) | (c ? ((MASK << (W - b)) & MASK) : 0); sc = (a >> (b - 1)) & 1; end
            7: r = (a == b) ? 1 : 0;
            8: r = (a != b) ? 1 : 0;
            9: r = (a < b) ? 1 : 0;
            10: begin s = a * b; r = s & MASK; sc = (s > MASK) ? 1 : 0; end
            default: ill = 1;
        endcase
        return {1'(ill), 1'(sc), 8'(r)};
    endfunction

    // One clock: drive inputs, check In_ready, advance model, check outputs
    task automatic cycle(input logic rst, input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [3:0] op, input logic ordy);
        int ready, acc;
        Reset_n = rst; In_valid = iv; InputA = a; InputB = b; SC_in = c; OP = op; Out_ready = ordy;
        #1;
        ready = (rst && m_left == 0 && (!m_valid || ordy)) ? 1 : 0;
        chk("in_ready", 32'(In_ready), 32'(ready));
        acc = (iv && ready) ? 1 : 0;
        if (!rst) begin
            m_valid = 0; m_left = 0; m_res = '0; m_just_reset = 1;
        end else begin
            m_just_reset = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_valid = 1; m_res = p_res; end
            end else if (m_valid != 0 && ordy && acc == 0) m_valid = 0;
            if (acc != 0) begin
                if (op == 4'd10) begin m_left = W; m_valid = 0; p_res = ref_op(a, b, c, op); end
                else begin m_valid = 1; m_res = ref_op(a, b, c, op); end
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        chk("out_valid", 32'(Out_valid), 32'(m_valid));
        chk("busy", 32'(Busy), (m_left > 0) ? 32'd1 : 32'd0);
        if (m_just_reset != 0) begin
            chk("rst_out", {24'd0, Out}, 32'd0);
            chk("rst_flags", {26'd0, SC_out, Zero, Parity, Odd, Illegal, Busy}, 32'd0);
        end else if (m_valid != 0) begin
            chk("out", {24'd0, Out}, {24'd0, m_res[7:0]});
            chk("sc_out", 32'(SC_out), 32'(m_res[8]));
            chk("illegal", 32'(Illegal), 32'(m_res[9]));
            chk("zero", 32'(Zero), 32'(m_res[7:0] == 8'd0));
            chk("parity", 32'(Parity), 32'(^m_res[7:0]));
            chk("odd", 32'(Odd), 32'(m_res[0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1);
    endtask

    initial begin
        int b2b [10] = '{5, 3, 0, 5, 1, 8, 2, 0, 1, 0};
        logic [7:0] held;
        m_res = '0; p_res = '0; m_valid = 0; m_left = 0; m_just_reset = 0;

        cycle(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1);

        cycle(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 4'd0, 1'b1);
        chk("lit_add_out", {24'd0, Out}, 32'h00);
        chk("lit_add_flags", {29'd0, Zero, SC_out, Parity}, 32'b110);
        chk("lit_add_valid", 32'(Out_valid), 32'd1);

        cycle(1'b1, 1'b1, 8'h04, 8'h01, 1'b1, 4'd1, 1'b1);
        chk("lit_sub1", {24'd0, Out}, 32'h02);
        cycle(1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 4'd1, 1'b1);
        chk("lit_sub2", {22'd0, Out, SC_out, Parity}, {22'd0, 8'hFF, 2'b10});
        cycle(1'b1, 1'b1, 8'h81, 8'h01, 1'b1, 4'd5, 1'b1);
        chk("lit_shl", {23'd0, Out, SC_out}, {23'd0, 8'h03, 1'b1});
        cycle(1'b1, 1'b1, 8'h81, 8'h09, 1'b0, 4'd6, 1'b1);
        chk("lit_shr", {23'd0, Out, SC_out}, {23'd0, 8'h00, 1'b0});

        cycle(1'b1, 1'b1, 8'h0F, 8'h11, 1'b0, 4'd10, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("lit_mul_busy", {30'd0, Busy, Out_valid}, 32'b10);
            cycle(1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 4'd0, 1'b1);
        end
        chk("lit_mul_busy_last", 32'(Busy), 32'd1);
        idle(1);
        chk("lit_mul1", {22'd0, Out_valid, Out, SC_out}, {22'd0, 1'b1, 8'hFF, 1'b0});
        cycle(1'b1, 1'b1, 8'h10, 8'h10, 1'b0, 4'd10, 1'b1);
        idle(8);
        chk("lit_mul2", {22'd0, Out, SC_out, Zero}, {22'd0, 8'h00, 2'b11});

        cycle(1'b1, 1'b1, 8'h21, 8'h13, 1'b0, 4'd0, 1'b1);
        held = Out;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 4'd3, 1'b0);
        chk("lit_hold", {23'd0, Out, Out_valid}, {23'd0, 8'h34, 1'b1});
        chk("lit_hold_same", {24'd0, Out}, {24'd0, held});
        idle(1);

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 8'h04, 8'h01, 1'b0, 4'(i), 1'b1);
            chk("lit_b2b", {24'd0, Out}, 32'(b2b[i]));
        end
        idle(1);

        cycle(1'b1, 1'b1, 8'h0F, 8'h11, 1'b0, 4'd10, 1'b1);
        idle(2);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1);
        chk("lit_rst_mul", {23'd0, Out_valid, Out}, 32'd0);
        idle(10);
        chk("lit_rst_discard", 32'(Out_valid), 32'd0);

        cycle(1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1, 4'd12, 1'b1);
        chk("lit_illegal", {22'd0, Out, Illegal, Zero}, {22'd0, 8'h00, 2'b11});

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            logic [7:0] b;
            op = ($urandom_range(0, 5) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            b  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 8'($urandom), b,
                  1'($urandom), op, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
